hpc3_rnd_source: RTL and testbench
==================================

// Module: hpc3_rnd_source
// PURPOSE
// - Producer end of the HPC3 randomness interface: turns a 128-bit seed into fresh
//   per-cycle masking randomness for NGADGETS parallel HPC3 AND gadgets (d*(d-1) bits each).
// - Sits between the top-level seed input and the rnd ports of the masked S-box datapath.
// - Each delivered word is consumed exactly once; the state advances only on a completed handshake.
// PARAMETERS
// - d          DEFAULTSHARES(2)  number of shares of the fed gadgets
// - NGADGETS   1                 number of HPC3 gadgets fed per cycle
// - RND_W      NGADGETS*d*(d-1)  output width (derived localparam); must be 1..128
// - WARMUP     4                 state advances after seeding before the first word is valid (>=1)
// - HEALTH_LIM 8                 consecutive identical words that trigger rnd_fault (RND_HEALTH_EN only)
// PORTS
// - clk         in   1      clock
// - syn_rst     in   1      synchronous reset, active-high
// - seed        in   128    reseed value
// - seed_valid  in   1      seed offered
// - seed_ready  out  1      seed accepted when seed_valid&&seed_ready at a rising edge
// - rnd_out     out  RND_W  randomness word, registered
// - rnd_valid   out  1      rnd_out is fresh
// - rnd_ready   in   1      consumer takes rnd_out at an edge with rnd_valid&&rnd_ready
// - rnd_fault   out  1      sticky health fault (tied 0 when RND_HEALTH_EN is undefined)
// BEHAVIOUR
// - State S[127:0]. One LFSR step: fb = S[127]^S[28]^S[26]^S[1]; S <= {S[126:0], fb}.
// - One "advance" = RND_W steps in a single cycle; rnd_out = S[RND_W-1:0] after the advance.
// - Seed load: S <= (seed==0) ? 128'h1 : seed. The all-zero state is unreachable.
// - FSM IDLE -> WARM -> RUN.
//   - IDLE: seed_ready=1, rnd_valid=0. A seed handshake loads S and enters WARM with wcnt=0.
//   - WARM: seed_ready=0, rnd_valid=0. Advance every cycle and increment wcnt.
//     When wcnt reaches WARMUP-1, go to RUN. rnd_valid rises exactly WARMUP edges after the seed edge.
//   - RUN: seed_ready=1, rnd_valid=1. Advance only on an edge where rnd_valid&&rnd_ready.
//     Otherwise hold S and rnd_out.
//     A seed handshake in RUN loads S and returns to WARM; rnd_valid drops at that edge.
// - Seed handshake and rnd handshake at the same RUN edge:
//   - Both complete; the consumer keeps the current word.
//   - The reload takes priority over the advance, so S = new seed.
// - Reset (any state, incl. mid-WARM):
//   - S=0, rnd_out=0, rnd_valid=0, seed_ready=0 while syn_rst=1; FSM=IDLE; wcnt=0.
//   - rnd_fault=0 and repeat counter cleared.
//   - seed_ready=1 in the first cycle after syn_rst deasserts.
// - rnd_out is never driven combinationally from seed; no word is ever delivered twice via handshake.
// CONFIGURATION
// - Macro RND_HEALTH_EN.
// - Defined: on each rnd handshake, compare the taken word with the previously taken word.
//   - Equal: rcnt++. Different: rcnt=0.
//   - When rcnt reaches HEALTH_LIM-1, rnd_fault is set (sticky) and rnd_valid is forced to 0.
//   - Only a reseed handshake or syn_rst clears rnd_fault and rcnt.
//   - The first word after a seed is never compared.
// - Undefined: no compare logic or counters; rnd_fault = 0 constantly.
// TESTING
// - Reset: hold syn_rst 3 cycles -> rnd_valid=0, rnd_out=0, seed_ready=0, rnd_fault=0.
//   - Then seed_ready=1 in the next cycle.
// - Warmup (d=2, NGADGETS=1): seed=128'h1, rnd_ready=1 from the start.
//   - S=0x5, 0x15, 0x55, 0x155 after warm cycles 1..4.
//   - rnd_valid=1 exactly 4 edges after the seed edge, rnd_out=2'b01.
// - Backpressure: in RUN hold rnd_ready=0 for 10 cycles -> rnd_out and S unchanged, rnd_valid stays 1.
//   - The next handshake advances exactly once.
// - Zero seed: seed=0 -> S loads 128'h1; outputs identical to the seed=128'h1 case.
// - Reseed collision: in RUN, seed_valid and rnd_ready both high at one edge.
//   - Current word taken, S=new seed, WARM entered, rnd_valid=0 for WARMUP cycles.
// - RND_HEALTH_EN (d=2, seed=128'h1, rnd_ready=1):
//   - The repeated 2'b01 words set rnd_fault after HEALTH_LIM identical takes; rnd_valid=0.
//   - Reseed with 128'hA5A5...A5 clears rnd_fault.

Source files
------------

// File: rtl/hpc3_rnd_source.sv
// hpc3_rnd_source
// Producer end of the HPC3 randomness interface. A 128-bit LFSR is seeded and
// then advanced RND_W steps per cycle, so each delivered word is made of fresh
// state bits. Each word is delivered once over a valid/ready handshake.
//
// Handshakes: a transfer happens at a rising edge where valid && ready are both
// high. Valid is never withdrawn without a transfer, except when a reseed is
// accepted or the health monitor faults. Ready never depends on valid.
//
// Optional feature, macro RND_HEALTH_EN: a repetition monitor over the words
// actually taken. It raises a sticky rnd_fault and stops delivery after
// HEALTH_LIM identical consecutive takes. When the macro is undefined,
// rnd_fault is tied to 0.
module hpc3_rnd_source #(
   parameter int d          = 2,
   parameter int NGADGETS   = 1,
   parameter int WARMUP     = 4,
   parameter int HEALTH_LIM = 8
) (
   input  logic                              i_clk,
   input  logic                              i_syn_rst,
   input  logic [127:0]                      i_seed,
   input  logic                              i_seed_valid,
   output logic                              o_seed_ready,
   output logic [NGADGETS*d*(d-1)-1:0]       o_rnd_out,
   output logic                              o_rnd_valid,
   input  logic                              i_rnd_ready,
   output logic                              o_rnd_fault
);

   localparam int RND_W  = NGADGETS * d * (d - 1);
   localparam int WCNT_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;

   // Reject configurations that would make the output width or counters meaningless
   if (RND_W < 1 || RND_W > 128 || WARMUP < 1 || HEALTH_LIM < 2) begin : g_cfg_check
      $error("hpc3_rnd_source: illegal parameter combination");
   end

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WARM = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   state_t              r_state;
   logic [127:0]        r_s;
   logic [RND_W-1:0]    r_rnd_out;
   logic                r_rnd_valid;
   logic                r_seed_ready;
   logic [WCNT_W-1:0]   r_wcnt;

   logic [127:0]        w_adv;
   logic [127:0]        w_seed_fixed;
   logic                w_seed_hs;
   logic                w_rnd_hs;

`ifdef RND_HEALTH_EN
   localparam int RCNT_W = $clog2(HEALTH_LIM);
   logic [RCNT_W-1:0]   r_rcnt;
   logic [RND_W-1:0]    r_prev;
   logic                r_have_prev;
   logic                r_fault;
`endif

   // RND_W LFSR steps unrolled into one combinational advance
   function automatic logic [127:0] f_advance(input logic [127:0] s);
      logic [127:0] t;
      t = s;
      for (int k = 0; k < RND_W; k++) begin
         t = {t[126:0], t[127] ^ t[28] ^ t[26] ^ t[1]};
      end
      return t;
   endfunction

   // Next LFSR state, seed fix-up for the unreachable all-zero state, handshakes
   always_comb begin
      w_adv        = f_advance(r_s);
      w_seed_fixed = (i_seed == 128'd0) ? 128'd1 : i_seed;
      w_seed_hs    = i_seed_valid && r_seed_ready;
      w_rnd_hs     = r_rnd_valid && i_rnd_ready;
   end

   // Control FSM with registered outputs; reseed beats advance on a collision
   always_ff @(posedge i_clk) begin
      if (i_syn_rst) begin
         r_state      <= ST_IDLE;
         r_s          <= 128'd0;
         r_rnd_out    <= '0;
         r_rnd_valid  <= 1'b0;
         r_seed_ready <= 1'b0;
         r_wcnt       <= '0;
`ifdef RND_HEALTH_EN
         r_rcnt       <= '0;
         r_prev       <= '0;
         r_have_prev  <= 1'b0;
         r_fault      <= 1'b0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_seed_ready <= 1'b1;
               r_rnd_valid  <= 1'b0;
               if (w_seed_hs) begin
                  r_s          <= w_seed_fixed;
                  r_state      <= ST_WARM;
                  r_wcnt       <= '0;
                  r_seed_ready <= 1'b0;
`ifdef RND_HEALTH_EN
                  r_rcnt       <= '0;
                  r_have_prev  <= 1'b0;
                  r_fault      <= 1'b0;
`endif
               end
            end

            ST_WARM: begin
               r_s       <= w_adv;
               r_rnd_out <= w_adv[RND_W-1:0];
               r_wcnt    <= r_wcnt + 1'b1;
               if (r_wcnt == WCNT_W'(WARMUP - 1)) begin
                  r_state      <= ST_RUN;
                  r_rnd_valid  <= 1'b1;
                  r_seed_ready <= 1'b1;
               end
            end

            ST_RUN: begin
               if (w_seed_hs) begin
                  // Consumer keeps the current word if it also took it this edge
                  r_s          <= w_seed_fixed;
                  r_state      <= ST_WARM;
                  r_wcnt       <= '0;
                  r_rnd_valid  <= 1'b0;
                  r_seed_ready <= 1'b0;
`ifdef RND_HEALTH_EN
                  r_rcnt       <= '0;
                  r_have_prev  <= 1'b0;
                  r_fault      <= 1'b0;
`endif
               end else if (w_rnd_hs) begin
                  r_s       <= w_adv;
                  r_rnd_out <= w_adv[RND_W-1:0];
`ifdef RND_HEALTH_EN
                  // First take after a seed only primes the comparison
                  r_prev      <= r_rnd_out;
                  r_have_prev <= 1'b1;
                  if (r_have_prev && (r_rnd_out == r_prev)) begin
                     r_rcnt <= r_rcnt + 1'b1;
                     if (r_rcnt == RCNT_W'(HEALTH_LIM - 2)) begin
                        r_fault     <= 1'b1;
                        r_rnd_valid <= 1'b0;
                     end
                  end else begin
                     r_rcnt <= '0;
                  end
`endif
               end
            end

            default: begin
               r_state      <= ST_IDLE;
               r_rnd_valid  <= 1'b0;
               r_seed_ready <= 1'b0;
            end
         endcase
      end
   end

   assign o_seed_ready = r_seed_ready;
   assign o_rnd_out    = r_rnd_out;
   assign o_rnd_valid  = r_rnd_valid;
`ifdef RND_HEALTH_EN
   assign o_rnd_fault  = r_fault;
`else
   assign o_rnd_fault  = 1'b0;
`endif

endmodule

// File: tb/tb_hpc3_rnd_source.sv
// Bench for hpc3_rnd_source (d=2, NGADGETS=1, WARMUP=4, HEALTH_LIM=8).
// A behavioural model tracks the LFSR state as an integer-like value, a
// countdown of remaining warm edges, and the log of words taken; it is checked
// against the DUT on every cycle after reset, plus literal pins on the model.
module tb_hpc3_rnd_source;

   localparam int D      = 2;
   localparam int NG     = 1;
   localparam int W      = NG * D * (D - 1);
   localparam int WARMUP = 4;
   localparam int HL     = 8;

   logic          i_clk = 1'b0;
   logic          i_syn_rst;
   logic [127:0]  i_seed;
   logic          i_seed_valid;
   logic          o_seed_ready;
   logic [W-1:0]  o_rnd_out;
   logic          o_rnd_valid;
   logic          i_rnd_ready;
   logic          o_rnd_fault;

   always #5 i_clk = ~i_clk;

   hpc3_rnd_source #(
      .d(D), .NGADGETS(NG), .WARMUP(WARMUP), .HEALTH_LIM(HL)
   ) dut (
      .i_clk(i_clk), .i_syn_rst(i_syn_rst), .i_seed(i_seed),
      .i_seed_valid(i_seed_valid), .o_seed_ready(o_seed_ready),
      .o_rnd_out(o_rnd_out), .o_rnd_valid(o_rnd_valid),
      .i_rnd_ready(i_rnd_ready), .o_rnd_fault(o_rnd_fault)
   );

   int n_cmp = 0;
   int n_bad = 0;
   logic cmp_en = 1'b0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // One whole-word advance: W single LFSR steps, straight from the tap rule
   function automatic logic [127:0] lfsr_adv(input logic [127:0] s);
      logic [127:0] t;
      logic fb;
      t = s;
      for (int k = 0; k < W; k++) begin
         fb = t[127] ^ t[28] ^ t[26] ^ t[1];
         t  = (t << 1) | {127'd0, fb};
      end
      return t;
   endfunction

   // ---------------- model ----------------
   logic [127:0] m_s;
   logic [W-1:0] m_out;
   logic         m_valid, m_sready, m_fault;
   int           m_warm;       // edges still to go before words become valid
   int           n_taken;
   logic [W-1:0] taken_q[$];   // words taken since the last seed

   initial begin
      m_s = '0; m_out = '0; m_valid = 0; m_sready = 0; m_fault = 0;
      m_warm = 0; n_taken = 0;
      forever begin
         logic seed_hs, rnd_hs;
         int run_len;
         @(posedge i_clk);
         if (i_syn_rst) begin
            m_s = '0; m_out = '0; m_valid = 0; m_sready = 0; m_fault = 0;
            m_warm = 0; taken_q.delete();
         end else begin
            seed_hs = i_seed_valid && m_sready;
            rnd_hs  = m_valid && i_rnd_ready;
            if (rnd_hs) n_taken++;
            if (seed_hs) begin
               m_s = (i_seed == 0) ? 128'd1 : i_seed;
               m_warm = WARMUP; m_valid = 0; m_sready = 0; m_fault = 0;
               taken_q.delete();
            end else if (m_warm > 0) begin
               m_s = lfsr_adv(m_s); m_out = m_s[W-1:0]; m_warm--;
               if (m_warm == 0) m_valid = 1;
            end else if (rnd_hs) begin
               taken_q.push_back(m_out);
`ifdef RND_HEALTH_EN
               // Length of the trailing run of identical taken words
               run_len = 0;
               for (int i = taken_q.size() - 1; i >= 0; i--) begin
                  if (taken_q[i] == m_out) run_len++;
                  else break;
               end
               if (run_len >= HL) begin m_fault = 1; m_valid = 0; end
`else
               run_len = 0;
`endif
               m_s = lfsr_adv(m_s); m_out = m_s[W-1:0];
            end
            if (!seed_hs && m_warm == 0) m_sready = 1;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   initial forever begin
      @(negedge i_clk);
      if (cmp_en) begin
         chk("cyc_rnd_out",    {{(128-W){1'b0}}, o_rnd_out}, {{(128-W){1'b0}}, m_out});
         chk("cyc_rnd_valid",  {127'd0, o_rnd_valid}, {127'd0, m_valid});
         chk("cyc_seed_ready", {127'd0, o_seed_ready}, {127'd0, m_sready});
         chk("cyc_rnd_fault",  {127'd0, o_rnd_fault}, {127'd0, m_fault});
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      @(negedge i_clk); #1;
      i_syn_rst = 1; i_seed_valid = 0; i_rnd_ready = 0;
      repeat (2) @(posedge i_clk);
      @(negedge i_clk); #1;
      i_syn_rst = 0;
      @(posedge i_clk);
   endtask

   // Seed with 0 or 1 and pin the warm-up sequence and valid timing
   task automatic warm_check(input logic [127:0] sd);
      logic [127:0] exp_s[4];
      exp_s[0] = 128'h5; exp_s[1] = 128'h15; exp_s[2] = 128'h55; exp_s[3] = 128'h155;
      @(negedge i_clk); #1;
      i_seed = sd; i_seed_valid = 1; i_rnd_ready = 1;
      @(posedge i_clk); #1;
      i_seed_valid = 0;
      @(negedge i_clk);
      chk("seed_load_state", m_s, 128'h1);
      chk("seed_edge_valid", {127'd0, o_rnd_valid}, 128'd0);
      for (int k = 1; k <= WARMUP; k++) begin
         @(posedge i_clk); @(negedge i_clk);
         chk($sformatf("warm_state_%0d", k), m_s, exp_s[k-1]);
         chk($sformatf("warm_valid_%0d", k), {127'd0, o_rnd_valid}, {127'd0, (k == WARMUP)});
      end
      chk("first_word", {{(128-W){1'b0}}, o_rnd_out}, 128'h1);
   endtask

   initial begin
      logic [127:0] snap_s, nxt;
      logic [W-1:0] snap_out;
      int base;
      i_syn_rst = 1; i_seed = '0; i_seed_valid = 0; i_rnd_ready = 0;

      // Reset held 3 cycles
      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      chk("rst_valid", {127'd0, o_rnd_valid}, 128'd0);
      chk("rst_out", {{(128-W){1'b0}}, o_rnd_out}, 128'd0);
      chk("rst_seed_ready", {127'd0, o_seed_ready}, 128'd0);
      chk("rst_fault", {127'd0, o_rnd_fault}, 128'd0);
      cmp_en = 1;
      #1 i_syn_rst = 0;
      @(posedge i_clk); @(negedge i_clk);
      chk("seed_ready_after_rst", {127'd0, o_seed_ready}, 128'd1);

      // Warm-up from seed 1, then stream words
      warm_check(128'h1);
      repeat (20) @(posedge i_clk);

      // Backpressure: 10 cycles without ready
      @(negedge i_clk); #1;
      i_rnd_ready = 0;
      snap_s = m_s; snap_out = m_out;
      repeat (10) @(posedge i_clk);
      @(negedge i_clk);
      chk("bp_hold_out", {{(128-W){1'b0}}, o_rnd_out}, {{(128-W){1'b0}}, snap_out});
      chk("bp_hold_valid", {127'd0, o_rnd_valid}, 128'd1);
      #1 i_rnd_ready = 1;
      @(posedge i_clk); #1;
      i_rnd_ready = 0;
      nxt = lfsr_adv(snap_s);
      @(negedge i_clk);
      chk("bp_one_advance", {{(128-W){1'b0}}, o_rnd_out}, {{(128-W){1'b0}}, nxt[W-1:0]});
      chk("bp_state", m_s, nxt);
      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      chk("bp_no_extra", {{(128-W){1'b0}}, o_rnd_out}, {{(128-W){1'b0}}, nxt[W-1:0]});

      // Zero seed behaves exactly like seed 1
      do_reset();
      warm_check(128'h0);
      repeat (15) @(posedge i_clk);

      // Reseed colliding with a take
      @(negedge i_clk); #1;
      i_rnd_ready = 1; i_seed = {16{8'hA5}}; i_seed_valid = 1;
      base = n_taken;
      @(posedge i_clk); #1;
      i_seed_valid = 0;
      @(negedge i_clk);
      chk("coll_state", m_s, {16{8'hA5}});
      chk("coll_taken", 128'(n_taken), 128'(base + 1));
      chk("coll_valid_drop", {127'd0, o_rnd_valid}, 128'd0);
      for (int k = 1; k <= WARMUP; k++) begin
         @(posedge i_clk); @(negedge i_clk);
         chk($sformatf("coll_warm_valid_%0d", k), {127'd0, o_rnd_valid}, {127'd0, (k == WARMUP)});
      end
      repeat (10) @(posedge i_clk);

`ifdef RND_HEALTH_EN
      // Repeated 01 words from seed 1 trip the health monitor
      do_reset();
      warm_check(128'h1);
      base = n_taken;
      for (int k = 0; k < 20; k++) begin
         @(posedge i_clk); @(negedge i_clk);
         if (o_rnd_fault) break;
      end
      chk("health_fault", {127'd0, o_rnd_fault}, 128'd1);
      chk("health_takes", 128'(n_taken - base), 128'(HL));
      chk("health_valid", {127'd0, o_rnd_valid}, 128'd0);
      @(negedge i_clk); #1;
      i_seed = {16{8'hA5}}; i_seed_valid = 1;
      @(posedge i_clk); #1;
      i_seed_valid = 0;
      @(negedge i_clk);
      chk("health_clear", {127'd0, o_rnd_fault}, 128'd0);
      repeat (10) @(posedge i_clk);
`endif

      @(negedge i_clk);
      cmp_en = 0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
